m_005_demux_1to2_stream: RTL and testbench
==========================================

# m_005_demux_1to2_stream

Registered 1:2 stream demultiplexer: routes each accepted input beat to output channel A or B according to a per-beat select, buffering each channel in its own FIFO so that one stalled channel does not block the other. It is the inverse of the team's 2:1 select path: one producer fans out to two consumers over valid/ready handshakes.

## Interface
- `WIDTH`, default 8: data width in bits.
- `DEPTH`, default 2: entries per channel FIFO. Must be a power of two, ≥ 2.

- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_ni`  input  1  reset; asynchronous assert, active-low.
- `data_i`  input  WIDTH  input beat payload.
- `sel_i`  input  1  destination of the beat: 0 = channel A, 1 = channel B.
- `valid_i`  input  1  input beat valid.
- `ready_o`  output  1  input beat accepted when `valid_i && ready_o`.
- `a_data_o`  output  WIDTH  channel A payload.
- `a_valid_o`  output  1  channel A beat valid.
- `a_ready_i`  input  1  channel A consumer ready.
- `b_data_o`  output  WIDTH  channel B payload.
- `b_valid_o`  output  1  channel B beat valid.
- `b_ready_i`  input  1  channel B consumer ready.
- `a_cnt_o`  output  16  beats delivered on channel A (only with `M005_BEAT_CNT_EN`).
- `b_cnt_o`  output  16  beats delivered on channel B (only with `M005_BEAT_CNT_EN`).

## Operation
- Each channel has its own FIFO of `DEPTH` × `WIDTH`, built from:
  - read and write pointers, each `$clog2(DEPTH)` bits, wrapping naturally;
  - an occupancy count, `$clog2(DEPTH)+1` bits, range 0..`DEPTH`.
- Full when count == `DEPTH`; empty when count == 0.
- `ready_o = sel_i ? !b_full : !a_full`. This is combinational on `sel_i` and the full flags only, and never depends on `a_ready_i` or `b_ready_i`.
- Accept is `valid_i && ready_o`. On accept, `data_i` is written to the selected FIFO at its write pointer, and that write pointer increments.
- `x_valid_o = !x_empty`. `x_data_o` is the storage entry at the read pointer, driven directly from storage with no extra register stage.
- Pop is `x_valid_o && x_ready_i`. On pop, the read pointer increments.
- Count update per channel:
  - push only: +1;
  - pop only: −1;
  - push and pop together: unchanged.
- Full FIFO with a pop in the same cycle: `ready_o` is still 0 for that channel. No push-through when full.
- Empty FIFO with a push: the beat is visible the next cycle. There is no same-cycle bypass.
- Beats are delivered in order within each channel. There is no ordering guarantee between channels.
- When `valid_i` = 0, the value of `sel_i` has no effect on state.
- Reset (async, any time, including mid-transfer):
  - pointers, counts and storage are cleared to 0, and all queued beats are discarded;
  - outputs are `a_valid_o` = `b_valid_o` = 0, `a_data_o` = `b_data_o` = 0;
  - `ready_o` = 1, because both FIFOs are empty;
  - counters are 0.

## Timing
- Latency from accept to `x_valid_o` high is 1 cycle, when that channel's FIFO was empty.
- Throughput is 1 beat/cycle per channel when the consumer holds ready high. For back-to-back operation, `DEPTH` ≥ 2 is sufficient.
- Producer rules, checked by assertion in the bench:
  - `data_i` and `sel_i` are held stable while `valid_i && !ready_o`;
  - `valid_i` is not withdrawn before acceptance.
- Outputs obey the same rule: `x_valid_o` and `x_data_o` hold until popped.
- Release of `rst_ni` is synchronous to `clk_i` at system level. The first accept is allowed in the first cycle after release.

## Configuration
- `M005_BEAT_CNT_EN` defined:
  - `a_cnt_o` and `b_cnt_o` exist;
  - each is a 16-bit register that increments on its channel's pop;
  - each wraps from 0xFFFF to 0x0000;
  - both reset to 0.
- `M005_BEAT_CNT_EN` not defined: the ports and registers are absent, and all other behaviour is identical.

## Test plan
- **Reset state:** assert `rst_ni` = 0 mid-stream with both FIFOs holding data. Required immediately, without a clock edge: both valids = 0 and both data = 0x00. After release: `ready_o` = 1.
- **Routing:** both consumers ready; send 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0) on consecutive cycles.
  - A emits 0x11, then 0x33.
  - B emits 0x22.
  - Each beat appears 1 cycle after its accept.
- **Full / backpressure:** `a_ready_i` = 0; push 0xA0, 0xA1 to A.
  - `ready_o` then = 0 while `sel_i` = 0, and = 1 while `sel_i` = 1.
  - A beat 0xB0 to B is accepted and delivered while A is stalled.
  - Releasing `a_ready_i` delivers 0xA0, then 0xA1.
- **Simultaneous push/pop:** A holds 1 entry with `a_ready_i` = 1 and `valid_i` = 1, `sel_i` = 0 every cycle for 8 cycles. Required: A's count stays constant, data is delivered in order, and there are no stall cycles.
- **Pointer wrap:** stream 3×`DEPTH` + 1 beats into B while toggling `b_ready_i` pseudo-randomly. Required: every beat is delivered in order, with no loss or duplication across pointer wrap.
- **Counters (with `M005_BEAT_CNT_EN`):** preload by delivering 65535 beats on A, then 1 more. Required: `a_cnt_o` reads 0xFFFF, then 0x0000, and `b_cnt_o` is unchanged.

Source files
------------

// File: rtl/m_005_demux_1to2_stream.sv
// m_005_demux_1to2_stream
// Registered 1:2 stream demultiplexer. Each accepted input beat is routed to
// channel A (sel_i = 0) or channel B (sel_i = 1) and queued in that channel's
// own FIFO, so a stalled consumer on one channel never blocks the other.
// Optional feature: define M005_BEAT_CNT_EN to add 16-bit delivered-beat
// counters a_cnt_o / b_cnt_o, one per output channel.
module m_005_demux_1to2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             sel_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] a_data_o,
  output logic             a_valid_o,
  input  logic             a_ready_i,
  output logic [WIDTH-1:0] b_data_o,
  output logic             b_valid_o,
  input  logic             b_ready_i
`ifdef M005_BEAT_CNT_EN
  ,
  output logic [15:0]      a_cnt_o,
  output logic [15:0]      b_cnt_o
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int CH_A = 0;
  localparam int CH_B = 1;

  // Per-channel FIFO state, indexed by channel (0 = A, 1 = B).
  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [CW-1:0]    cnt_q    [2];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;
  logic       accept;

  // Full/empty flags, input handshake and per-channel push/pop strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    full      = '0;
    empty     = '0;
    for (int c = 0; c < 2; c++) begin
      full[c]  = (cnt_q[c] == CW'(DEPTH));
      empty[c] = (cnt_q[c] == '0);
    end
    // Only the selected channel's full flag gates the producer; consumer
    // readies never reach ready_o, which keeps the input path short.
    ready_o   = sel_i ? !full[CH_B] : !full[CH_A];
    accept    = valid_i && ready_o;
    push      = {accept && sel_i, accept && !sel_i};
    out_ready = {b_ready_i, a_ready_i};
    pop       = ~empty & out_ready;
  end

  // Output channels read straight from storage at the read pointer.
  assign a_valid_o = !empty[CH_A];
  assign b_valid_o = !empty[CH_B];
  assign a_data_o  = mem_q[CH_A][rd_ptr_q[CH_A]];
  assign b_data_o  = mem_q[CH_B][rd_ptr_q[CH_B]];

  // FIFO storage, pointers and occupancy for both channels.
  // NOTE: state is updated with <= so every register samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        // NOTE: storage is cleared as well, so both data outputs read 0 while
        // in reset instead of showing stale payload.
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[c][e] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem_q[c][wr_ptr_q[c]] <= data_i;
          wr_ptr_q[c]           <= wr_ptr_q[c] + PW'(1);
        end
        if (pop[c]) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + PW'(1);
        end
        case ({push[c], pop[c]})
          2'b10:   cnt_q[c] <= cnt_q[c] + CW'(1);
          2'b01:   cnt_q[c] <= cnt_q[c] - CW'(1);
          default: cnt_q[c] <= cnt_q[c];
        endcase
      end
    end
  end

`ifdef M005_BEAT_CNT_EN
  // Delivered-beat counters; wrap naturally from 0xFFFF to 0x0000.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_cnt_o <= '0;
      b_cnt_o <= '0;
    end else begin
      if (pop[CH_A]) a_cnt_o <= a_cnt_o + 16'd1;
      if (pop[CH_B]) b_cnt_o <= b_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_005_demux_1to2_stream.sv
// tb_m_005_demux_1to2_stream
// Scoreboard bench: a queue per channel holds the beats the stream rules say
// must still be delivered; a negedge monitor compares the DUT against it.
// Build with M005_BEAT_CNT_EN defined to also exercise the beat counters.
module tb_m_005_demux_1to2_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [WIDTH-1:0] data_i;
  logic             sel_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_data_o;
  logic             a_valid_o;
  logic             a_ready_i;
  logic [WIDTH-1:0] b_data_o;
  logic             b_valid_o;
  logic             b_ready_i;
`ifdef M005_BEAT_CNT_EN
  logic [15:0]      a_cnt_o;
  logic [15:0]      b_cnt_o;
`endif

  m_005_demux_1to2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .sel_i     (sel_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_data_o  (a_data_o),
    .a_valid_o (a_valid_o),
    .a_ready_i (a_ready_i),
    .b_data_o  (b_data_o),
    .b_valid_o (b_valid_o),
    .b_ready_i (b_ready_i)
`ifdef M005_BEAT_CNT_EN
    ,
    .a_cnt_o   (a_cnt_o),
    .b_cnt_o   (b_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: beats accepted but not yet delivered, per channel.
  logic [WIDTH-1:0] qa [$];
  logic [WIDTH-1:0] qb [$];
  logic [15:0]      ca = '0;
  logic [15:0]      cb = '0;
  int               b_delivered = 0;
  logic             rand_a = 1'b0;
  logic             rand_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer must hold a stalled beat unchanged until it is accepted.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> (valid_i && $stable(data_i) && $stable(sel_i)))
    else $error("producer hold rule broken");

  // Monitor: compare outputs with the model, then advance the model to the
  // state the coming rising edge must produce.
  logic exp_rdy, exp_av, exp_bv;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      qa.delete();
      qb.delete();
      ca = '0;
      cb = '0;
    end else begin
      exp_rdy = sel_i ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      exp_av  = (qa.size() != 0);
      exp_bv  = (qb.size() != 0);
      check("ready_o", ready_o, exp_rdy);
      check("a_valid", a_valid_o, exp_av);
      check("b_valid", b_valid_o, exp_bv);
      if (exp_av && a_valid_o) check("a_data", a_data_o, qa[0]);
      if (exp_bv && b_valid_o) check("b_data", b_data_o, qb[0]);
`ifdef M005_BEAT_CNT_EN
      check("a_cnt", a_cnt_o, ca);
      check("b_cnt", b_cnt_o, cb);
`endif
      if (exp_av && a_ready_i) begin
        void'(qa.pop_front());
        ca = ca + 16'd1;
      end
      if (exp_bv && b_ready_i) begin
        void'(qb.pop_front());
        cb = cb + 16'd1;
        b_delivered++;
      end
      if (valid_i && exp_rdy) begin
        if (sel_i) qb.push_back(data_i);
        else       qa.push_back(data_i);
      end
    end
  end

  // Advance to just after the next rising edge; optionally shuffle readies.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_a) a_ready_i = 1'($urandom_range(0, 1));
    if (rand_b) b_ready_i = 1'($urandom_range(0, 1));
  endtask

  // Present one beat and hold it until accepted; n = cycles it took.
  task automatic send(input logic s, input logic [WIDTH-1:0] d, output int n);
    logic fired;
    n       = 0;
    fired   = 1'b0;
    sel_i   = s;
    data_i  = d;
    valid_i = 1'b1;
    do begin
      @(negedge clk_i);
      fired = ready_o;
      tick();
      n++;
    end while (!fired && n < 200);
    if (!fired) check("send_accept", fired, 1);
  endtask

  task automatic idle();
    valid_i = 1'b0;
    tick();
  endtask

  task automatic drain();
    int k = 0;
    valid_i = 1'b0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 100) begin
      tick();
      k++;
    end
    check("drain_done", qa.size() + qb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int n;
  int stalls;
  int b_start;

  initial begin
    rst_ni    = 1'b0;
    valid_i   = 1'b0;
    sel_i     = 1'b0;
    data_i    = '0;
    a_ready_i = 1'b1;
    b_ready_i = 1'b1;
    #2;
    check("rst_a_valid", a_valid_o, 0);
    check("rst_b_valid", b_valid_o, 0);
    check("rst_a_data", a_data_o, 0);
    check("rst_b_data", b_data_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check("ready_after_rst", ready_o, 1);

    // Routing with both consumers ready; each beat visible one cycle later.
    send(1'b0, 8'h11, n);
    check("route_a0_valid", a_valid_o, 1);
    check("route_a0_data", a_data_o, 8'h11);
    send(1'b1, 8'h22, n);
    check("route_b0_valid", b_valid_o, 1);
    check("route_b0_data", b_data_o, 8'h22);
    send(1'b0, 8'h33, n);
    check("route_a1_data", a_data_o, 8'h33);
    drain();

    // Full A: producer blocked for sel 0 only; B still flows.
    a_ready_i = 1'b0;
    send(1'b0, 8'hA0, n);
    send(1'b0, 8'hA1, n);
    valid_i = 1'b0;
    sel_i   = 1'b0;
    #1;
    check("full_rdy_sel0", ready_o, 0);
    sel_i = 1'b1;
    #1;
    check("full_rdy_sel1", ready_o, 1);
    send(1'b1, 8'hB0, n);
    check("b_while_a_stall", b_data_o, 8'hB0);
    idle();
    idle();
    check("a_still_held", a_data_o, 8'hA0);
    a_ready_i = 1'b1;
    drain();

    // Simultaneous push/pop with one entry held: no stall cycles.
    a_ready_i = 1'b0;
    send(1'b0, 8'h50, n);
    a_ready_i = 1'b1;
    stalls    = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 8'(8'h51 + i), n);
      stalls += n - 1;
    end
    check("pushpop_stalls", stalls, 0);
    drain();

    // Pointer wrap on B with a random consumer.
    b_start = b_delivered;
    rand_b  = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 1; i++) send(1'b1, 8'(8'h80 + i), n);
    valid_i   = 1'b0;
    rand_b    = 1'b0;
    b_ready_i = 1'b1;
    drain();
    check("wrap_b_count", b_delivered - b_start, 3 * DEPTH + 1);

    // Random mixed traffic.
    rand_a = 1'b1;
    rand_b = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(1'($urandom_range(0, 1)), 8'($urandom), n);
    end
    rand_a    = 1'b0;
    rand_b    = 1'b0;
    a_ready_i = 1'b1;
    b_ready_i = 1'b1;
    drain();

    // Reset mid-stream with both FIFOs holding data.
    a_ready_i = 1'b0;
    b_ready_i = 1'b0;
    send(1'b0, 8'h61, n);
    send(1'b1, 8'h62, n);
    send(1'b0, 8'h63, n);
    idle();
    check("pre_rst_a_valid", a_valid_o, 1);
    check("pre_rst_b_valid", b_valid_o, 1);
    @(posedge clk_i);
    #3;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    #1;
    check("midrst_a_valid", a_valid_o, 0);
    check("midrst_b_valid", b_valid_o, 0);
    check("midrst_a_data", a_data_o, 0);
    check("midrst_b_data", b_data_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    check("midrst_ready", ready_o, 1);
    a_ready_i = 1'b1;
    b_ready_i = 1'b1;
    tick();

`ifdef M005_BEAT_CNT_EN
    // Counter wrap: 65535 beats on A, then one more.
    for (int i = 0; i < 65535; i++) send(1'b0, 8'(i), n);
    idle();
    tick();
    check("a_cnt_ffff", a_cnt_o, 16'hFFFF);
    send(1'b0, 8'h5A, n);
    idle();
    tick();
    check("a_cnt_wrap", a_cnt_o, 16'h0000);
    check("b_cnt_hold", b_cnt_o, cb);
`endif

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
